// File: rtl/mc_ctrl_if.sv
// Memory-side handshake bundle of the multicycle controller.
// The controller drives the request and the memory answers with mem_ready.
interface mc_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic IorD;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output IorD,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  IorD,
    output mem_ready
  );
endinterface

// File: rtl/mc_ctrl.sv
// Multicycle MIPS-subset control FSM (Moore outputs, memory-gated fetch).
// Define MC_CTRL_RETIRE_CNT_EN to build the retired-instruction counter.
module mc_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  mc_ctrl_if.master   bus,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic [1:0]  RegDst,
  output logic [1:0]  MemtoReg,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ALUOp,
  output logic [1:0]  PCSrc,
  output logic [3:0]  state,
  output logic [31:0] retire_cnt
);

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, EXEC_I,
    MEM_ADDR, MEM_RD, MEM_WR, WB_R,
    WB_I, WB_MEM, BRANCH, JAL, JR
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_LUI = 3'b011;

  state_t st_q;
  state_t dec_nxt;

  // The condition flag is consumed by the datapath's PCWriteCond gate.
  logic unused_zero;
  assign unused_zero = zero;

  logic is_r, is_addu, is_subu, is_jr;
  logic is_ori, is_lui, is_lw, is_sw;
  logic is_beq, is_jal;

  assign is_r    = opcode == 6'h00;
  assign is_addu = is_r && funct == 6'h21;
  assign is_subu = is_r && funct == 6'h23;
  assign is_jr   = is_r && funct == 6'h08;
  assign is_ori  = opcode == 6'h0D;
  assign is_lui  = opcode == 6'h0F;
  assign is_lw   = opcode == 6'h23;
  assign is_sw   = opcode == 6'h2B;
  assign is_beq  = opcode == 6'h04;
  assign is_jal  = opcode == 6'h03;

  always_comb begin
    dec_nxt = FETCH;
    unique case (1'b1)
      is_addu, is_subu: dec_nxt = EXEC_R;
      is_ori, is_lui:   dec_nxt = EXEC_I;
      is_lw, is_sw:     dec_nxt = MEM_ADDR;
      is_beq:           dec_nxt = BRANCH;
      is_jal:           dec_nxt = JAL;
      is_jr:            dec_nxt = JR;
      default:          dec_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q <= FETCH;
    end else begin
      unique case (st_q)
        FETCH:    if (bus.mem_ready) st_q <= DECODE;
        DECODE:   st_q <= dec_nxt;
        EXEC_R:   st_q <= WB_R;
        EXEC_I:   st_q <= WB_I;
        MEM_ADDR: st_q <= is_lw ? MEM_RD : MEM_WR;
        MEM_RD:   if (bus.mem_ready) st_q <= WB_MEM;
        MEM_WR:   if (bus.mem_ready) st_q <= FETCH;
        default:  st_q <= FETCH;
      endcase
    end
  end

  assign state = st_q;

  always_comb begin
    bus.mem_req = 1'b0;
    bus.mem_we  = 1'b0;
    bus.IorD    = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 2'b00;
    MemtoReg    = 2'b00;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = OP_ADD;
    PCSrc       = 2'b00;
    // Reset must silence the bus at once, not at the next edge.
    if (reset_n) begin
      unique case (st_q)
        FETCH: begin
          bus.mem_req = 1'b1;
          ALUSrcB     = 2'b01;
          IRWrite     = bus.mem_ready;
          PCWrite     = bus.mem_ready;
        end
        DECODE: ALUSrcB = 2'b11;
        EXEC_R: begin
          ALUSrcA = 1'b1;
          ALUOp   = is_subu ? OP_SUB : OP_ADD;
        end
        EXEC_I: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          ALUOp   = is_lui ? OP_LUI : OP_OR;
        end
        MEM_ADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        MEM_RD: begin
          bus.mem_req = 1'b1;
          bus.IorD    = 1'b1;
        end
        MEM_WR: begin
          bus.mem_req = 1'b1;
          bus.mem_we  = 1'b1;
          bus.IorD    = 1'b1;
        end
        WB_R: begin
          RegWrite = 1'b1;
          RegDst   = 2'b01;
        end
        WB_I: RegWrite = 1'b1;
        WB_MEM: begin
          RegWrite = 1'b1;
          MemtoReg = 2'b01;
        end
        BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = OP_SUB;
          PCWriteCond = 1'b1;
          PCSrc       = 2'b01;
        end
        JAL: begin
          RegWrite = 1'b1;
          RegDst   = 2'b10;
          MemtoReg = 2'b10;
          PCWrite  = 1'b1;
          PCSrc    = 2'b10;
        end
        JR: begin
          PCWrite = 1'b1;
          PCSrc   = 2'b11;
        end
        default: ;
      endcase
    end
  end

`ifdef MC_CTRL_RETIRE_CNT_EN
  logic [31:0] retire_q;
  logic        retire;

  always_comb begin
    retire = 1'b0;
    unique case (st_q)
      DECODE:  retire = dec_nxt == FETCH;
      MEM_WR:  retire = bus.mem_ready;
      WB_R, WB_I, WB_MEM,
      BRANCH, JAL, JR: retire = 1'b1;
      default: retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      retire_q <= '0;
    end else if (retire) begin
      retire_q <= retire_q + 32'd1;
    end
  end

  assign retire_cnt = retire_q;
`else
  assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: directed instruction traces, per-cycle checks.
// Counter checks follow MC_CTRL_RETIRE_CNT_EN the same way the design does.
module tb_mc_ctrl;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_EXEC_R = 4'd2;
  localparam logic [3:0] S_EXEC_I = 4'd3;
  localparam logic [3:0] S_MADDR  = 4'd4;
  localparam logic [3:0] S_MRD    = 4'd5;
  localparam logic [3:0] S_MWR    = 4'd6;
  localparam logic [3:0] S_WB_R   = 4'd7;
  localparam logic [3:0] S_WB_I   = 4'd8;
  localparam logic [3:0] S_WB_MEM = 4'd9;
  localparam logic [3:0] S_BRANCH = 4'd10;
  localparam logic [3:0] S_JAL    = 4'd11;
  localparam logic [3:0] S_JR     = 4'd12;

  logic        clk;
  logic        reset_n;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        PCWrite, PCWriteCond, IRWrite, RegWrite, ALUSrcA;
  logic [1:0]  RegDst, MemtoReg, ALUSrcB, PCSrc;
  logic [2:0]  ALUOp;
  logic [3:0]  state;
  logic [31:0] retire_cnt;

  mc_ctrl_if bus ();

  mc_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .opcode      (opcode),
    .funct       (funct),
    .zero        (zero),
    .bus         (bus.master),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IRWrite     (IRWrite),
    .RegWrite    (RegWrite),
    .RegDst      (RegDst),
    .MemtoReg    (MemtoReg),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUOp       (ALUOp),
    .PCSrc       (PCSrc),
    .state       (state),
    .retire_cnt  (retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [22:0] w;
    logic [31:0] cnt;
    string       nm;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_cnt = '0;
  logic        idle_mr = 1'b0;

  logic [22:0] act;
  assign act = {state, bus.mem_req, bus.mem_we, bus.IorD,
                PCWrite, PCWriteCond, IRWrite, RegWrite,
                RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSrc};

  // Expected control word per state, straight from the output table.
  function automatic logic [22:0] expw(input logic [3:0] st,
                                       input logic mr,
                                       input logic [2:0] op);
    logic mq, we, iod, pw, pwc, irw, rw, asa;
    logic [1:0] rd, m2r, asb, pcs;
    logic [2:0] aop;
    {mq, we, iod, pw, pwc, irw, rw, asa} = '0;
    rd = 2'b00; m2r = 2'b00; asb = 2'b00;
    pcs = 2'b00; aop = 3'b000;
    case (st)
      S_FETCH:  begin mq = 1; asb = 2'b01; irw = mr; pw = mr; end
      S_DECODE: asb = 2'b11;
      S_EXEC_R: begin asa = 1; aop = op; end
      S_EXEC_I: begin asa = 1; asb = 2'b10; aop = op; end
      S_MADDR:  begin asa = 1; asb = 2'b10; end
      S_MRD:    begin mq = 1; iod = 1; end
      S_MWR:    begin mq = 1; we = 1; iod = 1; end
      S_WB_R:   begin rw = 1; rd = 2'b01; end
      S_WB_I:   rw = 1;
      S_WB_MEM: begin rw = 1; m2r = 2'b01; end
      S_BRANCH: begin
        asa = 1; aop = 3'b001; pwc = 1; pcs = 2'b01;
      end
      S_JAL: begin
        rw = 1; rd = 2'b10; m2r = 2'b10; pw = 1; pcs = 2'b10;
      end
      S_JR: begin pw = 1; pcs = 2'b11; end
      default: ;
    endcase
    return {st, mq, we, iod, pw, pwc, irw, rw,
            rd, m2r, asa, asb, aop, pcs};
  endfunction

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (act !== e.w || retire_cnt !== e.cnt) begin
        errors++;
        $display("FAIL %s: got word=%h cnt=%0d, want word=%h cnt=%0d",
                 e.nm, act, retire_cnt, e.w, e.cnt);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, want %h", nm, got, want);
    end
  endtask

  task automatic push(input logic [3:0] st, input logic mr,
                      input logic [2:0] op, input string nm);
    exp_t e;
    bus.mem_ready = mr;
    e.w   = expw(st, mr, op);
    e.cnt = exp_cnt;
    e.nm  = nm;
    sb.push_back(e);
  endtask

  task automatic step(input logic [3:0] st, input logic mr,
                      input logic [2:0] op, input string nm);
    push(st, mr, op, nm);
    @(posedge clk);
    #1;
  endtask

  task automatic bump();
`ifdef MC_CTRL_RETIRE_CNT_EN
    exp_cnt = exp_cnt + 32'd1;
`endif
  endtask

  task automatic run_instr(input logic [5:0] opc, input logic [5:0] fn,
                           input int fs, input int ms, input string nm);
    opcode = 6'h3F;
    funct  = 6'h3F;
    repeat (fs) step(S_FETCH, 1'b0, 3'b000, nm);
    step(S_FETCH, 1'b1, 3'b000, nm);
    opcode = opc;
    funct  = fn;
    idle_mr = ~idle_mr;
    step(S_DECODE, idle_mr, 3'b000, nm);
    if (opc == 6'h00 && fn == 6'h21) begin
      step(S_EXEC_R, idle_mr, 3'b000, nm);
      step(S_WB_R, idle_mr, 3'b000, nm);
    end else if (opc == 6'h00 && fn == 6'h23) begin
      step(S_EXEC_R, idle_mr, 3'b001, nm);
      step(S_WB_R, idle_mr, 3'b000, nm);
    end else if (opc == 6'h00 && fn == 6'h08) begin
      step(S_JR, idle_mr, 3'b000, nm);
    end else if (opc == 6'h0D) begin
      step(S_EXEC_I, idle_mr, 3'b010, nm);
      step(S_WB_I, idle_mr, 3'b000, nm);
    end else if (opc == 6'h0F) begin
      step(S_EXEC_I, idle_mr, 3'b011, nm);
      step(S_WB_I, idle_mr, 3'b000, nm);
    end else if (opc == 6'h23) begin
      step(S_MADDR, idle_mr, 3'b000, nm);
      repeat (ms) step(S_MRD, 1'b0, 3'b000, nm);
      step(S_MRD, 1'b1, 3'b000, nm);
      step(S_WB_MEM, idle_mr, 3'b000, nm);
    end else if (opc == 6'h2B) begin
      step(S_MADDR, idle_mr, 3'b000, nm);
      repeat (ms) step(S_MWR, 1'b0, 3'b000, nm);
      step(S_MWR, 1'b1, 3'b000, nm);
    end else if (opc == 6'h04) begin
      step(S_BRANCH, idle_mr, 3'b000, nm);
    end else if (opc == 6'h03) begin
      step(S_JAL, idle_mr, 3'b000, nm);
    end
    bump();
  endtask

  logic [5:0] t_opc[10] = '{6'h00, 6'h00, 6'h0D, 6'h0F, 6'h23,
                            6'h2B, 6'h04, 6'h04, 6'h03, 6'h00};
  logic [5:0] t_fn[10]  = '{6'h21, 6'h23, 6'h00, 6'h00, 6'h00,
                            6'h00, 6'h00, 6'h00, 6'h00, 6'h08};
  int         t_fs[10]  = '{0, 1, 0, 0, 0, 0, 0, 0, 2, 0};
  int         t_ms[10]  = '{0, 0, 0, 0, 3, 1, 0, 0, 0, 0};
  string      t_nm[10]  = '{"addu", "subu", "ori", "lui", "lw",
                            "sw", "beq_z0", "beq_z1", "jal", "jr"};

  task automatic run_table();
    for (int i = 0; i < 10; i++) begin
      zero = (i == 7);
      run_instr(t_opc[i], t_fn[i], t_fs[i], t_ms[i], t_nm[i]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n       = 1'b0;
    opcode        = 6'h00;
    funct         = 6'h00;
    zero          = 1'b0;
    bus.mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_word", {9'd0, act}, 32'd0);
    chk("reset_cnt", retire_cnt, 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    run_table();
    run_instr(6'h3E, 6'h00, 0, 0, "nop_unsup");
    run_instr(6'h00, 6'h3F, 0, 0, "nop_rfunct");

    // sw stalled in MEM_WR, then reset pulsed in mid-request.
    opcode = 6'h3F;
    funct  = 6'h3F;
    step(S_FETCH, 1'b1, 3'b000, "sw_rst");
    opcode = 6'h2B;
    step(S_DECODE, 1'b0, 3'b000, "sw_rst");
    step(S_MADDR, 1'b0, 3'b000, "sw_rst");
    step(S_MWR, 1'b0, 3'b000, "sw_rst");
    push(S_MWR, 1'b0, 3'b000, "sw_rst");
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("rst_state", {28'd0, state}, {28'd0, S_FETCH});
    chk("rst_cnt", retire_cnt, 32'd0);
    @(posedge clk);
    #1;
    chk("rst_hold_req", {31'd0, bus.mem_req}, 32'd0);
    reset_n = 1'b1;
    exp_cnt = '0;
    #1;
    chk("post_rst_req", {31'd0, bus.mem_req}, 32'd1);

    run_table();
`ifdef MC_CTRL_RETIRE_CNT_EN
    chk("cnt_after_10", retire_cnt, 32'd10);
    dut.retire_q = 32'hFFFF_FFFF;
    exp_cnt      = 32'hFFFF_FFFF;
`else
    chk("cnt_after_10", retire_cnt, 32'd0);
`endif
    run_instr(6'h00, 6'h21, 0, 0, "wrap_addu");
    step(S_FETCH, 1'b0, 3'b000, "tail");
    step(S_FETCH, 1'b0, 3'b000, "tail");

    for (int k = 0; k < 4 && sb.size() > 0; k++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 Clock and reset SHALL be one clock, `clk`, with asynchronous active-low reset `reset_n`.
REQ-002 Port list (name, direction, width, meaning), clock and reset first:
- `clk` input 1: rising-edge clock.
- `reset_n` input 1: async active-low reset.
- `opcode` input 6: IR[31:26].
- `funct` input 6: IR[5:0].
- `zero` input 1: ALU result-equal flag.
- `mem_ready` input 1: memory completes the current request this cycle.
REQ-003 Handshake outputs:
- `mem_req` output 1: memory request.
- `mem_we` output 1: request is a write.
- `IorD` output 1: address source, 0 = PC, 1 = ALUOut.
REQ-004 Write-enable outputs:
- `PCWrite` output 1: unconditional PC write.
- `PCWriteCond` output 1: PC write gated by `zero`.
- `IRWrite` output 1: instruction register write.
- `RegWrite` output 1: register file write.
REQ-005 Datapath-select outputs:
- `RegDst` output 2: 00 rt, 01 rd, 10 $31.
- `MemtoReg` output 2: 00 ALUOut, 01 MDR, 10 PC.
- `ALUSrcA` output 1: 0 PC, 1 A.
- `ALUSrcB` output 2: 00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- `ALUOp` output 3: 000 add, 001 sub, 010 or, 011 lui.
- `PCSrc` output 2: 00 ALU, 01 ALUOut, 10 jump target, 11 rs.
- `state` output 4: current state, debug only.
- `retire_cnt` output 32: retired instruction count.

Function
REQ-006 Supported instructions (others SHALL execute as nop):
- addu (funct 0x21), subu (0x23), jr (0x08).
- ori (0x0D), lui (0x0F), lw (0x23), sw (0x2B), beq (0x04), jal (0x03).
REQ-007 States SHALL be FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_R, WB_I, WB_MEM, BRANCH, JAL, JR; outputs decode from `state` only (Moore), except where REQ-008 and REQ-009 gate on `mem_ready`.
REQ-008 FETCH: `mem_req`=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=add, PCSrc=00; `IRWrite`/`PCWrite` SHALL be high only in the cycle `mem_ready`=1, which also advances to DECODE; otherwise hold FETCH.
REQ-009 MEM_RD/MEM_WR: `mem_req`=1, IorD=1, `mem_we`=1 only in MEM_WR; hold until `mem_ready`=1, then MEM_RD->WB_MEM, MEM_WR->FETCH.
REQ-010 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=add; next state by decode: addu/subu->EXEC_R, ori/lui->EXEC_I, lw/sw->MEM_ADDR, beq->BRANCH, jal->JAL, jr->JR, unsupported->FETCH.
REQ-011 EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp add/sub per funct -> WB_R.
REQ-012 WB_R: RegWrite=1, RegDst=01, MemtoReg=00 -> FETCH.
REQ-013 EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp or/lui -> WB_I.
REQ-014 WB_I: RegWrite=1, RegDst=00, MemtoReg=00 -> FETCH.
REQ-015 MEM_ADDR: ALUSrcA=1, ALUSrcB=10, add -> MEM_RD (lw) or MEM_WR (sw).
REQ-016 WB_MEM: RegWrite=1, RegDst=00, MemtoReg=01 -> FETCH.
REQ-017 BRANCH: ALUSrcA=1, ALUSrcB=00, sub, PCWriteCond=1, PCSrc=01 -> FETCH.
REQ-018 JAL: RegWrite=1, RegDst=10, MemtoReg=10, PCWrite=1, PCSrc=10 -> FETCH.
REQ-019 JR: PCWrite=1, PCSrc=11 -> FETCH.
REQ-020 Defaults: every strobe not listed for a state SHALL be 0, and every select not listed SHALL be 0.
REQ-021 `mem_ready` outside FETCH/MEM_RD/MEM_WR SHALL be ignored; `opcode`/`funct` SHALL be sampled only in DECODE and later states.
REQ-022 Latency with `mem_ready` tied 1:
- 3 cycles: beq, jal, jr.
- 4 cycles: R-type, I-type ALU, sw.
- 5 cycles: lw.
- Each cycle `mem_ready`=0 in a memory state adds 1 cycle.

Reset
REQ-023 `reset_n`=0 SHALL immediately force state FETCH, `retire_cnt`=0, and all strobes 0 (`mem_req` included), aborting any pending memory request.
REQ-024 After `reset_n` deasserts, FETCH SHALL assert `mem_req` on the first cycle.

Configuration
REQ-025 With `MC_CTRL_RETIRE_CNT_EN` defined:
- `retire_cnt` SHALL increment by 1 on every transition into FETCH from any state other than FETCH, unsupported-nop included.
- It SHALL wrap from 0xFFFFFFFF to 0.
- Without the macro, `retire_cnt` SHALL be constant 0 and no counter register SHALL exist.

Verification
REQ-026 addu (opcode 0, funct 0x21), `mem_ready`=1 -> states FETCH, DECODE, EXEC_R, WB_R; in WB_R RegWrite=1, RegDst=01; back in FETCH at cycle 5.
REQ-027 lw, `mem_ready` low for 3 cycles in MEM_RD -> `mem_req`=1, IorD=1 for 4 cycles; WB_MEM MemtoReg=01, RegDst=00; 8 cycles total.
REQ-028 beq with `zero`=0 then `zero`=1 -> PCWriteCond=1, PCSrc=01 in BRANCH both times; 3 cycles each.
REQ-029 jal -> JAL state with RegDst=10, MemtoReg=10, PCWrite=1, PCSrc=10.
REQ-030 `reset_n` pulsed low mid-MEM_WR with `mem_ready`=0 -> `mem_req`/`mem_we` drop asynchronously; state=FETCH; counter=0.
REQ-031 With the macro, 10 instructions run -> `retire_cnt`=10; preload 0xFFFFFFFF and retire one -> 0.
